// File: rtl/four_bit_adder_pkg.sv
// Shared types for the 4-bit adder checker: run-state enum, default width,
// and the operand/result transaction record.
package four_bit_adder_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic [DEF_WIDTH-1:0] sum;
    logic                 carry;
  } txn_t;

endpackage

// File: rtl/adder_ref_model.sv
// Combinational golden adder: (WIDTH+1)-bit zero-extended a + b.
module adder_ref_model
  import four_bit_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   expected
);

  assign expected = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/four_bit_adder_checker.sv
// Response checker for the adder stream: one-stage compare pipeline, saturating
// pass/fail counters, sticky error. CHECKER_FIRST_FAIL_CAPTURE_EN adds first-fail capture.
module four_bit_adder_checker
  import four_bit_adder_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_W     = 16,
  parameter int EXP_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             error,
  output logic             done
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_sum,
  output logic             fail_carry,
  output logic [CNT_W-1:0] fail_idx
`endif
);

  localparam int ACC_W = (EXP_COUNT > 1) ? $clog2(EXP_COUNT + 1) : 1;

  state_t           state;
  logic [ACC_W-1:0] acc_cnt;
  logic             hs, last_hs, run_start;

  logic             cmp_vld;
  logic [WIDTH-1:0] cmp_a, cmp_b, cmp_sum;
  logic             cmp_carry;
  logic [WIDTH:0]   expected;
  logic             match;

  assign in_ready  = (state == RUN) &&
                     ((EXP_COUNT == 0) || (32'(acc_cnt) < EXP_COUNT));
  assign hs        = in_valid && in_ready;
  assign last_hs   = hs && (EXP_COUNT != 0) && (32'(acc_cnt) + 1 == EXP_COUNT);
  assign run_start = start && ((state == IDLE) || (state == DONE));

  adder_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a        (cmp_a),
    .b        (cmp_b),
    .expected (expected)
  );

  assign match = ({cmp_carry, cmp_sum} == expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      cmp_vld   <= 1'b0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      cmp_sum   <= '0;
      cmp_carry <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      error     <= 1'b0;
      done      <= 1'b0;
    end else begin
      cmp_vld <= hs;
      if (hs) begin
        cmp_a     <= a;
        cmp_b     <= b;
        cmp_sum   <= sum;
        cmp_carry <= carry;
        if (EXP_COUNT != 0) acc_cnt <= acc_cnt + ACC_W'(1);
      end

      // Retire the compare; counters hold at all-ones instead of wrapping
      if (cmp_vld) begin
        if (match) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
          error <= 1'b1;
        end
      end

      case (state)
        IDLE, DONE: if (start) begin
          state    <= RUN;
          done     <= 1'b0;
          acc_cnt  <= '0;
          pass_cnt <= '0;
          fail_cnt <= '0;
          error    <= 1'b0;
        end
        RUN:   if (last_hs) state <= DRAIN;
        // The final capture always retires on the edge after entering DRAIN
        DRAIN: if (cmp_vld) begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
  logic [CNT_W-1:0] seq_idx, cap_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_idx    <= '0;
      cap_idx    <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_sum   <= '0;
      fail_carry <= 1'b0;
      fail_idx   <= '0;
    end else if (run_start) begin
      seq_idx    <= '0;
      cap_idx    <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_sum   <= '0;
      fail_carry <= 1'b0;
      fail_idx   <= '0;
    end else begin
      if (hs) begin
        cap_idx <= seq_idx;
        seq_idx <= seq_idx + CNT_W'(1);
      end
      // error still low means this is the run's first mismatch
      if (cmp_vld && !match && !error) begin
        fail_a     <= cmp_a;
        fail_b     <= cmp_b;
        fail_sum   <= cmp_sum;
        fail_carry <= cmp_carry;
        fail_idx   <= cap_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_four_bit_adder_checker.sv
// Scoreboard bench for four_bit_adder_checker; honours CHECKER_FIRST_FAIL_CAPTURE_EN.
module tb_four_bit_adder_checker;
  import four_bit_adder_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  a = '0, b = '0, sum = '0;
  logic        carry = 1'b0;
  logic [15:0] pass_cnt, fail_cnt;
  logic        error, done;

  logic        s_start = 1'b0, s_valid = 1'b0, s_ready;
  logic [3:0]  s_a = '0, s_b = '0, s_sum = '0;
  logic        s_carry = 1'b0;
  logic [1:0]  s_pass, s_fail;
  logic        s_error, s_done;

`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
  logic [3:0]  fail_a, fail_b, fail_sum, sf_a, sf_b, sf_sum;
  logic        fail_carry, sf_carry;
  logic [15:0] fail_idx;
  logic [1:0]  sf_idx;
`endif

  four_bit_adder_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sum(sum), .carry(carry),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .error(error), .done(done)
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    , .fail_a(fail_a), .fail_b(fail_b), .fail_sum(fail_sum),
    .fail_carry(fail_carry), .fail_idx(fail_idx)
`endif
  );

  four_bit_adder_checker #(.CNT_W(2), .EXP_COUNT(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .a(s_a), .b(s_b), .sum(s_sum), .carry(s_carry),
    .pass_cnt(s_pass), .fail_cnt(s_fail), .error(s_error), .done(s_done)
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    , .fail_a(sf_a), .fail_b(sf_b), .fail_sum(sf_sum),
    .fail_carry(sf_carry), .fail_idx(sf_idx)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit m; int cyc; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Reference: the result word is correct when carry*16+sum equals a+b.
  function automatic bit model_match(input txn_t t);
    return (int'(t.carry) * 16 + int'(t.sum)) == (int'(t.a) + int'(t.b));
  endfunction

  function automatic txn_t rand_txn(input bit bad);
    txn_t t;
    int   r;
    t.a = 4'($urandom_range(0, 15));
    t.b = 4'($urandom_range(0, 15));
    r   = int'(t.a) + int'(t.b);
    if (bad) r = (r + 1 + int'($urandom_range(0, 30))) % 32;
    t.sum   = 4'(r % 16);
    t.carry = (r >= 16);
    return t;
  endfunction

  // Monitor: every counter step retires the oldest issued transaction
  int prev_tot = 0, prev_pass = 0;
  bit m_err = 1'b0;
  always @(negedge clk) begin
    int   tot;
    exp_t e;
    tot = int'(pass_cnt) + int'(fail_cnt);
    if (rst_n && tot == prev_tot + 1) begin
      if (q.size() == 0) chk("sb_unexpected_retire", 1, 0);
      else begin
        e = q.pop_front();
        if (!e.m) m_err = 1'b1;
        chk("sb_pass_step", int'(pass_cnt) - prev_pass, int'(e.m));
        chk("sb_latency", cyc - e.cyc, 2);
        chk("sb_error", int'(error), int'(m_err));
      end
    end else if (tot < prev_tot) m_err = 1'b0;
    prev_tot  = tot;
    prev_pass = int'(pass_cnt);
  end

  task automatic send(input txn_t t);
    int n = 0;
    @(negedge clk);
    a = t.a; b = t.b; sum = t.sum; carry = t.carry; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 10) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      q.push_back('{m: model_match(t), cyc: cyc});
      @(posedge clk); #1 in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Called right after the last handshake edge
  task automatic end_check(input string nm, input int ep, input int ef, input int ee);
    @(negedge clk);
    chk({nm, "_done_early"}, int'(done), 0);
    @(negedge clk);
    chk({nm, "_done"}, int'(done), 1);
    chk({nm, "_pass"}, int'(pass_cnt), ep);
    chk({nm, "_fail"}, int'(fail_cnt), ef);
    chk({nm, "_error"}, int'(error), ee);
    chk({nm, "_ready_done"}, int'(in_ready), 0);
  endtask

  txn_t plan [4];
  initial begin
    plan[0] = '{a: 4'd7,  b: 4'd7, sum: 4'd14, carry: 1'b0};
    plan[1] = '{a: 4'd9,  b: 4'd7, sum: 4'd0,  carry: 1'b1};
    plan[2] = '{a: 4'd11, b: 4'd7, sum: 4'd2,  carry: 1'b1};
    plan[3] = '{a: 4'd11, b: 4'd9, sum: 4'd4,  carry: 1'b1};
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    txn_t t;
    int   ep, ef, hs;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_pass", int'(pass_cnt), 0);
    chk("rst_fail", int'(fail_cnt), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;

    // start with in_valid in IDLE: only start acts
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; a = 4'd1; b = 4'd1; sum = 4'd5;
    #1 chk("start_ready_low", int'(in_ready), 0);
    @(negedge clk); start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) send(plan[i]);
    end_check("clean", 4, 0, 0);

    // One corrupted transaction
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      t = plan[i];
      if (i == 1) t.sum = 4'd3;
      send(t);
    end
    end_check("bad", 3, 1, 1);
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
    chk("ff_idx", int'(fail_idx), 1);
    chk("ff_a", int'(fail_a), 9);
    chk("ff_b", int'(fail_b), 7);
    chk("ff_sum", int'(fail_sum), 3);
    chk("ff_carry", int'(fail_carry), 1);
`endif

    // Randomized runs with occasional corruption
    for (int r = 0; r < 4; r++) begin
      pulse_start();
      ep = 0; ef = 0;
      for (int i = 0; i < 4; i++) begin
        t = rand_txn($urandom_range(0, 2) == 0);
        if (model_match(t)) ep++; else ef++;
        send(t);
      end
      end_check("rand", ep, ef, int'(ef > 0));
    end

    // in_valid held for 6 cycles
    pulse_start();
    t = rand_txn(1'b0);
    a = t.a; b = t.b; sum = t.sum; carry = t.carry;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); in_valid = 1'b1;
      #1;
      if (in_ready) begin
        hs++;
        q.push_back('{m: model_match(t), cyc: cyc});
      end
    end
    in_valid = 1'b0;
    chk("hold_handshakes", hs, 4);
    chk("hold_ready_after", int'(in_ready), 0);
    chk("hold_total", int'(pass_cnt) + int'(fail_cnt), 4);
    chk("hold_done", int'(done), 1);

    // Reset mid-run after 2 handshakes
    pulse_start();
    send(rand_txn(1'b0));
    send(rand_txn(1'b1));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", int'(in_ready), 0);
    chk("mid_rst_pass", int'(pass_cnt), 0);
    chk("mid_rst_fail", int'(fail_cnt), 0);
    chk("mid_rst_error", int'(error), 0);
    chk("mid_rst_done", int'(done), 0);
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk); #1 chk("post_rst_idle_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) send(rand_txn(1'b0));
    end_check("after_rst", 4, 0, 0);

    // start during RUN is ignored; start in DONE clears
    pulse_start();
    send(plan[0]);
    send(plan[1]);
    pulse_start();
    chk("run_start_ignored", int'(pass_cnt), 2);
    send(plan[2]);
    send(plan[3]);
    end_check("run_start", 4, 0, 0);
    pulse_start();
    #1;
    chk("restart_done", int'(done), 0);
    chk("restart_pass", int'(pass_cnt), 0);
    chk("restart_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) send(plan[i]);
    end_check("restart", 4, 0, 0);

    // Saturation on the CNT_W=2, unlimited instance
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t = rand_txn(1'b0);
      @(negedge clk);
      s_a = t.a; s_b = t.b; s_sum = t.sum; s_carry = t.carry; s_valid = 1'b1;
      #1 chk("sat_ready", int'(s_ready), 1);
    end
    @(negedge clk); s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_pass", int'(s_pass), 3);
    chk("sat_fail", int'(s_fail), 0);
    chk("sat_error", int'(s_error), 0);
    chk("sat_done", int'(s_done), 0);
    chk("sb_leftover", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
